// File: rtl/mac_seq_pkg.sv
// Shared opcodes, feed encodings, bank ids and FSM state types for the
// INT8 MAC command sequencer.
package mac_seq_pkg;

  typedef enum logic {
    OP_LOAD_W  = 1'b0,
    OP_COMPUTE = 1'b1
  } cmd_op_e;

  localparam logic [1:0] FEED_LOCAL   = 2'b00;
  localparam logic [1:0] FEED_CASCADE = 2'b01;

  // Activation-to-result latency of the MAC engine.
  localparam int MAC_LAT = 3;

  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  typedef enum logic {
    LD_IDLE,
    LD_LOAD
  } load_state_e;

  typedef enum logic {
    CP_IDLE,
    CP_RUN
  } comp_state_e;

endpackage

// File: rtl/mac_seq_loader.sv
// DEPTH-beat weight-bank load engine: issues the bank-load strobe, then the
// upstream weight-beat requests one cycle later, and pulses done on the last beat.
module mac_seq_loader
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic       start_target,
  input  logic       start_src,
  output logic       busy,
  output logic       target,
  output logic       src,
  output logic       load_bb_a,
  output logic       load_bb_b,
  output logic       w_take,
  output logic [1:0] feed_sel,
  output logic       done
);

  localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(DEPTH - 1);

  load_state_e      state_q, state_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             target_q, src_q, w_take_q;
  logic             load_strobe;

  // NOTE: every signal is given a default before the case so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    load_strobe = 1'b0;
    case (state_q)
      LD_IDLE: begin
        if (start) begin
          state_d = LD_LOAD;
          beat_d  = '0;
        end
      end
      LD_LOAD: begin
        load_strobe = 1'b1;
        if (beat_q == LAST_BEAT) begin
          state_d = LD_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= LD_IDLE;
      beat_q   <= '0;
      target_q <= BANK_A;
      src_q    <= 1'b0;
      w_take_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      w_take_q <= load_strobe;
      if (start) begin
        target_q <= start_target;
        src_q    <= start_src;
      end
    end
  end

  // The engine registers the load strobe, so weight beats trail it by one cycle.
  assign load_bb_a = load_strobe && (target_q == BANK_A);
  assign load_bb_b = load_strobe && (target_q == BANK_B);
  assign w_take    = w_take_q;
  assign feed_sel  = (w_take_q && src_q) ? FEED_CASCADE : FEED_LOCAL;
  assign done      = w_take_q && (state_q == LD_IDLE);
  assign busy      = (state_q == LD_LOAD) || w_take_q;
  assign target    = target_q;
  assign src       = src_q;

endmodule

// File: rtl/mac_int8_seq.sv
// In-order LOAD_W / COMPUTE dispatcher for one INT8 MAC engine with
// ping-pong weight banks; tracks bank validity and the active bank.
module mac_int8_seq
  import mac_seq_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic             cmd_src,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_release,
  output logic             load_bb_a,
  output logic             load_bb_b,
  output logic             load_buf_sel,
  output logic [1:0]       feed_sel,
  output logic             zero_en,
  output logic             ena,
  output logic             w_take,
  output logic             x_take,
  output logic             res_valid,
  output logic             busy,
  output logic [1:0]       bank_valid
);

  cmd_op_e            op;
  logic               active_q, active_d;
  logic [1:0]         valid_q, valid_d;
  comp_state_e        cp_state_q, cp_state_d;
  logic [LEN_W-1:0]   remain_q, remain_d;
  logic               release_q, release_d;
  logic               do_release;
  logic               buf_sel_q;
  logic [MAC_LAT-1:0] res_pipe_q;

  logic ld_busy, ld_target, ld_src, ld_done;
  logic load_target, load_ok, comp_ok, ld_start, cp_start;

  assign op = cmd_op_e'(cmd_op);

  // Fill the active bank first; only once it holds weights prefetch the other.
  assign load_target = valid_q[active_q] ? ~active_q : active_q;

  assign load_ok = !(&valid_q)
                && !(!cmd_src && (cp_state_q == CP_RUN))
                && !ld_busy;

  assign comp_ok = (cp_state_q == CP_IDLE)
                && !(ld_busy && !ld_src)
                && !(ld_busy && (ld_target == active_q))
                && valid_q[active_q];

  assign cmd_ready = !clr && ((op == OP_COMPUTE) ? comp_ok : load_ok);
  assign ld_start  = cmd_valid && cmd_ready && (op == OP_LOAD_W);
  assign cp_start  = cmd_valid && cmd_ready && (op == OP_COMPUTE);

  mac_seq_loader #(
    .DEPTH(DEPTH)
  ) u_loader (
    .clk         (clk),
    .clr         (clr),
    .start       (ld_start),
    .start_target(load_target),
    .start_src   (cmd_src),
    .busy        (ld_busy),
    .target      (ld_target),
    .src         (ld_src),
    .load_bb_a   (load_bb_a),
    .load_bb_b   (load_bb_b),
    .w_take      (w_take),
    .feed_sel    (feed_sel),
    .done        (ld_done)
  );

  always_comb begin
    cp_state_d = cp_state_q;
    remain_d   = remain_q;
    release_d  = release_q;
    do_release = 1'b0;
    case (cp_state_q)
      CP_IDLE: begin
        if (cp_start) begin
          if (cmd_len == '0) begin
            do_release = cmd_release;
          end else begin
            cp_state_d = CP_RUN;
            remain_d   = cmd_len;
            release_d  = cmd_release;
          end
        end
      end
      CP_RUN: begin
        remain_d = remain_q - 1'b1;
        if (remain_q == LEN_W'(1)) begin
          cp_state_d = CP_IDLE;
          do_release = release_q;
        end
      end
      default: cp_state_d = CP_IDLE;
    endcase
  end

  // A release and a load completion never touch the same bank: loads issued
  // while a bank is active always target the other one.
  always_comb begin
    valid_d  = valid_q;
    active_d = active_q;
    if (do_release) begin
      valid_d[active_q] = 1'b0;
      active_d          = ~active_q;
    end
    if (ld_done) begin
      valid_d[ld_target] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cp_state_q <= CP_IDLE;
      remain_q   <= '0;
      release_q  <= 1'b0;
      active_q   <= BANK_A;
      valid_q    <= 2'b00;
      buf_sel_q  <= BANK_A;
      res_pipe_q <= '0;
    end else begin
      cp_state_q <= cp_state_d;
      remain_q   <= remain_d;
      release_q  <= release_d;
      active_q   <= active_d;
      valid_q    <= valid_d;
      res_pipe_q <= {res_pipe_q[MAC_LAT-2:0], x_take};
      if (cp_start && (cmd_len != '0)) begin
        buf_sel_q <= active_q;
      end
    end
  end

  assign x_take       = (cp_state_q == CP_RUN);
  assign load_buf_sel = buf_sel_q;
  assign res_valid    = res_pipe_q[MAC_LAT-1];
  assign zero_en      = !res_valid;
  assign busy         = ld_busy || x_take || (|res_pipe_q);
  assign ena          = busy;
  assign bank_valid   = valid_q;

endmodule

// File: tb/tb_mac_int8_seq.sv
// Directed bench for mac_int8_seq: per-cycle output trace plus hand-computed
// cycle offsets relative to each command's accept cycle.
module tb_mac_int8_seq;
  import mac_seq_pkg::*;

  localparam int HIST = 4096;
  localparam int I_RDY = 4, I_LBA = 5, I_LBB = 6, I_SEL = 7, I_ZERO = 8;
  localparam int I_ENA = 9, I_WT = 10, I_XT = 11, I_RV = 12, I_BUSY = 13;

  logic        clk, clr, cmd_valid, cmd_ready, cmd_op, cmd_src, cmd_release;
  logic [15:0] cmd_len;
  logic        load_bb_a, load_bb_b, load_buf_sel, zero_en, ena;
  logic        w_take, x_take, res_valid, busy;
  logic [1:0]  feed_sel, bank_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic [15:0] hist [HIST];

  mac_int8_seq #(.DEPTH(3), .LEN_W(16)) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_len(cmd_len),
    .cmd_release(cmd_release), .load_bb_a(load_bb_a), .load_bb_b(load_bb_b),
    .load_buf_sel(load_buf_sel), .feed_sel(feed_sel), .zero_en(zero_en),
    .ena(ena), .w_take(w_take), .x_take(x_take), .res_valid(res_valid),
    .busy(busy), .bank_valid(bank_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < HIST)
      hist[cyc] <= {2'b00, busy, res_valid, x_take, w_take, ena, zero_en,
                    load_buf_sel, load_bb_b, load_bb_a, cmd_ready, feed_sel, bank_valid};
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input int b, input int c);
    if (c < 0 || c >= HIST) return 1'bx;
    return hist[c][b];
  endfunction

  function automatic logic [1:0] bank_at(input int c);
    if (c < 0 || c >= HIST) return 2'bxx;
    return hist[c][1:0];
  endfunction

  function automatic logic [1:0] feed_at(input int c);
    if (c < 0 || c >= HIST) return 2'bxx;
    return hist[c][3:2];
  endfunction

  function automatic int cnt(input int b, input int lo, input int hi);
    int n = 0;
    for (int c = lo; c <= hi; c++)
      if (c >= 0 && c < HIST && hist[c][b] === 1'b1) n++;
    return n;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one command and holds it until accepted or the budget expires;
  // returns the accept cycle, or -1 on timeout.
  task automatic send(input logic op, input logic src, input logic [15:0] len,
                      input logic rel, input int budget, output int acc);
    acc = -1;
    cmd_valid = 1'b1; cmd_op = op; cmd_src = src; cmd_len = len; cmd_release = rel;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        acc = cyc;
        break;
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int d, c, c2, l, start_cyc;
    int overlap;

    clr = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD_W; cmd_src = 1'b0;
    cmd_len = 16'd0; cmd_release = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_load_bb_a", load_bb_a, 0);
    check("rst_load_bb_b", load_bb_b, 0);
    check("rst_load_buf_sel", load_buf_sel, 0);
    check("rst_w_take", w_take, 0);
    check("rst_x_take", x_take, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ena", ena, 0);
    check("rst_feed_sel", feed_sel, 2'b00);
    check("rst_zero_en", zero_en, 1);
    check("rst_bank_valid", bank_valid, 2'b00);
    @(posedge clk);
    #1;
    clr = 1'b0; cmd_valid = 1'b0;
    start_cyc = cyc;

    // Local load into A straight after reset.
    send(OP_LOAD_W, 1'b0, 16'd0, 1'b0, 50, d);
    check("t1_accepted", d >= 0, 1);
    wait_cycles(8);
    check("t1_lba_count", cnt(I_LBA, d, d + 7), 3);
    check("t1_lba_first", bit_at(I_LBA, d + 1), 1);
    check("t1_lba_last", bit_at(I_LBA, d + 3), 1);
    check("t1_lba_after", bit_at(I_LBA, d + 4), 0);
    check("t1_wt_count", cnt(I_WT, d, d + 7), 3);
    check("t1_wt_not_early", bit_at(I_WT, d + 1), 0);
    check("t1_wt_first", bit_at(I_WT, d + 2), 1);
    check("t1_lbb_count", cnt(I_LBB, d, d + 7), 0);
    check("t1_bank_before", bank_at(d + 4), 2'b00);
    check("t1_bank_after", bank_at(d + 5), 2'b01);
    check("t1_busy_tail", bit_at(I_BUSY, d + 4), 1);
    check("t1_busy_done", bit_at(I_BUSY, d + 5), 0);

    // COMPUTE len=5 with release on A.
    send(OP_COMPUTE, 1'b0, 16'd5, 1'b1, 50, c);
    wait_cycles(12);
    check("t2_xt_count", cnt(I_XT, c, c + 11), 5);
    check("t2_xt_first", bit_at(I_XT, c + 1), 1);
    check("t2_xt_last", bit_at(I_XT, c + 5), 1);
    check("t2_xt_after", bit_at(I_XT, c + 6), 0);
    check("t2_sel_a", cnt(I_SEL, c + 1, c + 5), 0);
    check("t2_rv_count", cnt(I_RV, c, c + 11), 5);
    check("t2_rv_early", bit_at(I_RV, c + 3), 0);
    check("t2_rv_first", bit_at(I_RV, c + 4), 1);
    check("t2_rv_last", bit_at(I_RV, c + 8), 1);
    check("t2_rv_after", bit_at(I_RV, c + 9), 0);
    check("t2_zero_mask", bit_at(I_ZERO, c + 4), 0);
    check("t2_zero_idle", bit_at(I_ZERO, c + 9), 1);
    check("t2_bank_pre_rel", bank_at(c + 5), 2'b01);
    check("t2_bank_post_rel", bank_at(c + 6), 2'b00);
    check("t2_ena_tail", bit_at(I_ENA, c + 8), 1);
    check("t2_busy_done", bit_at(I_BUSY, c + 9), 0);

    // Active is now B: a local load must land in B.
    send(OP_LOAD_W, 1'b0, 16'd0, 1'b0, 50, d);
    wait_cycles(8);
    check("t2b_lbb_count", cnt(I_LBB, d, d + 7), 3);
    check("t2b_lba_count", cnt(I_LBA, d, d + 7), 0);
    check("t2b_bank", bank_at(d + 5), 2'b10);

    // COMPUTE len=8 on B overlapped by a cascade load into A.
    send(OP_COMPUTE, 1'b0, 16'd8, 1'b0, 50, c);
    send(OP_LOAD_W, 1'b1, 16'd0, 1'b0, 50, l);
    wait_cycles(14);
    check("t3_load_b2b", l, c + 1);
    check("t3_sel_b", cnt(I_SEL, c + 1, c + 8), 8);
    check("t3_overlap", {bit_at(I_LBA, c + 3), bit_at(I_XT, c + 3)}, 2'b11);
    check("t3_lba_count", cnt(I_LBA, c, c + 13), 3);
    check("t3_feed_pre", feed_at(c + 2), FEED_LOCAL);
    check("t3_feed_first", feed_at(c + 3), FEED_CASCADE);
    check("t3_feed_last", feed_at(c + 5), FEED_CASCADE);
    check("t3_feed_post", feed_at(c + 6), FEED_LOCAL);
    check("t3_bank_pre", bank_at(c + 5), 2'b10);
    check("t3_bank_both", bank_at(c + 6), 2'b11);
    check("t3_rv_count", cnt(I_RV, c, c + 13), 8);

    // Both banks valid: a third load waits for the release.
    send(OP_COMPUTE, 1'b0, 16'd2, 1'b1, 50, c);
    send(OP_LOAD_W, 1'b1, 16'd0, 1'b0, 50, l);
    wait_cycles(10);
    check("t4_stall_rdy1", bit_at(I_RDY, c + 1), 0);
    check("t4_stall_rdy2", bit_at(I_RDY, c + 2), 0);
    check("t4_load_acc", l, c + 3);
    check("t4_bank_rel", bank_at(c + 3), 2'b01);
    check("t4_lbb_count", cnt(I_LBB, l, l + 6), 3);
    check("t4_bank_refill", bank_at(l + 5), 2'b11);

    // Release A, then a local load is blocked by a RUN on B.
    send(OP_COMPUTE, 1'b0, 16'd3, 1'b1, 50, c);
    wait_cycles(10);
    check("t5_sel_a", cnt(I_SEL, c + 1, c + 3), 0);
    check("t5_bank_pre", bank_at(c + 3), 2'b11);
    check("t5_bank_post", bank_at(c + 4), 2'b10);
    send(OP_COMPUTE, 1'b0, 16'd4, 1'b0, 50, c2);
    send(OP_LOAD_W, 1'b0, 16'd0, 1'b0, 50, l);
    wait_cycles(10);
    check("t5_rdy_last_x", bit_at(I_RDY, c2 + 4), 0);
    check("t5_xt_last", bit_at(I_XT, c2 + 4), 1);
    check("t5_load_acc", l, c2 + 5);
    check("t5_sel_b", cnt(I_SEL, c2 + 1, c2 + 4), 4);
    check("t5_lba_count", cnt(I_LBA, l, l + 6), 3);
    check("t5_bank", bank_at(l + 5), 2'b11);

    // len=0 releases, then COMPUTE with no valid bank stalls.
    send(OP_COMPUTE, 1'b0, 16'd0, 1'b1, 50, c);
    send(OP_COMPUTE, 1'b0, 16'd0, 1'b1, 50, c2);
    send(OP_COMPUTE, 1'b0, 16'd1, 1'b0, 10, d);
    check("t6_len0_b2b", c2, c + 1);
    check("t6_bank_rel1", bank_at(c + 1), 2'b01);
    check("t6_bank_rel2", bank_at(c2 + 1), 2'b00);
    check("t6_no_xt", cnt(I_XT, c, c + 12), 0);
    check("t6_no_busy", cnt(I_BUSY, c, c + 6), 0);
    check("t6_nobank_rdy", bit_at(I_RDY, c2 + 3), 0);
    check("t6_nobank_stall", d, -1);

    // clr during load beat 2 (load targets B since active is B).
    send(OP_LOAD_W, 1'b0, 16'd0, 1'b0, 50, d);
    @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    wait_cycles(3);
    check("t7_lbb_beat2", bit_at(I_LBB, d + 2), 1);
    check("t7_clr_lbb", bit_at(I_LBB, d + 3), 0);
    check("t7_clr_lba", bit_at(I_LBA, d + 3), 0);
    check("t7_clr_wt", bit_at(I_WT, d + 3), 0);
    check("t7_clr_busy", bit_at(I_BUSY, d + 3), 0);
    check("t7_clr_zero", bit_at(I_ZERO, d + 3), 1);
    check("t7_clr_feed", feed_at(d + 3), FEED_LOCAL);
    check("t7_clr_bank", bank_at(d + 3), 2'b00);
    send(OP_LOAD_W, 1'b0, 16'd0, 1'b0, 50, d);
    wait_cycles(8);
    check("t7_fresh_lba", cnt(I_LBA, d, d + 6), 3);
    check("t7_fresh_lbb", cnt(I_LBB, d, d + 6), 0);
    check("t7_fresh_bank", bank_at(d + 5), 2'b01);

    overlap = 0;
    for (int k = start_cyc; k < cyc && k < HIST; k++)
      if (hist[k][I_LBA] === 1'b1 && hist[k][I_LBB] === 1'b1) overlap++;
    check("bank_strobe_overlap", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
